// File: rtl/dffr_ureg.sv
// rtl/dffr_ureg.sv - WIDTH-bit universal register: hold, load, shift, rotate, count up/down
module dffr_ureg #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter bit          COUNT_SAT = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST      = RESET_VAL[WIDTH-1:0];

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_UP    = 3'b110;
  localparam logic [2:0] MODE_DOWN  = 3'b111;

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_min;

  assign at_max = (q == ALL_ONES);
  assign at_min = (q == ALL_ZERO);

  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD: nxt = q;
      MODE_LOAD: nxt = d;
      MODE_SHL:  nxt = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  nxt = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
      // saturating counters park at the rail instead of wrapping
      MODE_UP:   nxt = (COUNT_SAT && at_max) ? q : q + ONE;
      MODE_DOWN: nxt = (COUNT_SAT && at_min) ? q : q - ONE;
      default:   nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= RST;
    end else if (en) begin
      q <= nxt;
    end
  end

  assign q_     = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign tc     = en & ~clr & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_min));

endmodule

// File: tb/tb_dffr_ureg.sv
// tb/tb_dffr_ureg.sv - randomized check of dffr_ureg (wrap and saturating) against an arithmetic model
module tb_dffr_ureg;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       clr, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q0, qn0, q1, qn1;
  logic       sl0, sr0, tc0, sl1, sr1, tc1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] m0, m1;

  always #5 clk = ~clk;

  dffr_ureg #(.WIDTH(8), .RESET_VAL(32'h0000_00A5), .COUNT_SAT(1'b0)) dut_wrap (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .q(q0), .q_(qn0), .sout_l(sl0), .sout_r(sr0), .tc(tc0)
  );

  dffr_ureg #(.WIDTH(8), .RESET_VAL(32'h0000_00A5), .COUNT_SAT(1'b1)) dut_sat (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .q(q1), .q_(qn1), .sout_l(sl1), .sout_r(sr1), .tc(tc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: register value as a plain integer in 0..255
  function automatic logic [7:0] model_next(input logic [7:0] cur, input bit sat,
                                            input logic c, input logic e, input logic [2:0] md,
                                            input logic [7:0] dd, input logic sr, input logic sl);
    int v;
    if (c) return RV;
    if (!e) return cur;
    v = cur;
    case (md)
      3'd0: v = v;
      3'd1: v = dd;
      3'd2: v = (v * 2 + sr) % 256;
      3'd3: v = v / 2 + sl * 128;
      3'd4: v = (v * 2) % 256 + v / 128;
      3'd5: v = v / 2 + (v % 2) * 128;
      3'd6: v = sat ? ((v == 255) ? 255 : v + 1) : (v + 1) % 256;
      default: v = sat ? ((v == 0) ? 0 : v - 1) : (v + 255) % 256;
    endcase
    return v[7:0];
  endfunction

  function automatic logic model_tc(input logic [7:0] cur, input logic c, input logic e,
                                    input logic [2:0] md);
    if (c || !e) return 1'b0;
    return (md == 3'd6 && cur == 8'd255) || (md == 3'd7 && cur == 8'd0);
  endfunction

  task automatic step(input logic c, input logic e, input logic [2:0] md,
                      input logic [7:0] dd, input logic sr, input logic sl);
    clr = c; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl;
    #1;
    check("tc_wrap", tc0, model_tc(m0, c, e, md));
    check("tc_sat",  tc1, model_tc(m1, c, e, md));
    if (!$isunknown(m0)) begin
      check("sout_l_pre", sl0, m0 / 128);
      check("sout_r_pre", sr0, m0 % 2);
    end
    @(posedge clk);
    m0 = model_next(m0, 1'b0, c, e, md, dd, sr, sl);
    m1 = model_next(m1, 1'b1, c, e, md, dd, sr, sl);
    #1;
    check("q_wrap",  q0,  m0);
    check("qn_wrap", qn0, 8'd255 - m0);
    check("sl_wrap", sl0, m0 / 128);
    check("sr_wrap", sr0, m0 % 2);
    check("q_sat",   q1,  m1);
    check("qn_sat",  qn1, 8'd255 - m1);
    check("sl_sat",  sl1, m1 / 128);
    check("sr_sat",  sr1, m1 % 2);
  endtask

  initial begin
    logic [7:0] dv;
    m0 = 'x; m1 = 'x;
    clr = 0; en = 0; mode = 0; d = 0; sin_r = 0; sin_l = 0;
    @(negedge clk);

    // clear wins over load
    step(1, 1, 3'b001, 8'hFF, 0, 0);
    check("plan_clear_q",  q0,  8'hA5);
    check("plan_clear_qn", qn0, 8'h5A);
    clr = 1; #1;
    check("plan_clear_tc", tc0, 1'b0);

    // load then hold with en=0
    step(0, 1, 3'b001, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b110, 8'h00, 0, 0);
    check("plan_hold", q0, 8'h3C);

    // shift / rotate
    step(0, 1, 3'b001, 8'h81, 0, 0);
    check("plan_sout_l_81", sl0, 1'b1);
    step(0, 1, 3'b010, 8'h00, 1, 0);
    check("plan_shl", q0, 8'h03);
    step(0, 1, 3'b011, 8'h00, 0, 0);
    check("plan_shr", q0, 8'h01);
    step(0, 1, 3'b101, 8'h00, 0, 0);
    check("plan_ror", q0, 8'h80);
    step(0, 1, 3'b100, 8'h00, 0, 0);
    check("plan_rol", q0, 8'h01);

    // count boundaries on both variants
    step(0, 1, 3'b001, 8'hFE, 0, 0);
    step(0, 1, 3'b110, 8'h00, 0, 0);
    check("plan_up_ff", q0, 8'hFF);
    step(0, 1, 3'b110, 8'h00, 0, 0);
    check("plan_wrap_up", q0, 8'h00);
    check("plan_sat_up",  q1, 8'hFF);
    step(0, 1, 3'b001, 8'h00, 0, 0);
    step(0, 1, 3'b111, 8'h00, 0, 0);
    check("plan_wrap_dn", q0, 8'hFF);
    check("plan_sat_dn",  q1, 8'h00);

    // clear mid-count, then resume from the reset value
    step(0, 1, 3'b001, 8'h10, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'b110, 8'h00, 0, 0);
    check("plan_cnt13", q0, 8'h13);
    step(1, 1, 3'b110, 8'h00, 0, 0);
    check("plan_midclr", q0, 8'hA5);
    step(0, 1, 3'b110, 8'h00, 0, 0);
    check("plan_resume", q0, 8'hA6);

    // random traffic, biased toward counter rails
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 5)
        0: dv = 8'h00;
        1: dv = 8'hFF;
        2: dv = 8'hFE;
        3: dv = 8'h01;
        default: dv = 8'($urandom);
      endcase
      step(($urandom % 20) == 0, ($urandom % 4) != 0, 3'($urandom), dv,
           1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
